// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline: stall, IF flush, operand selects, terminate drain.
// Optional HAZARD_STATS_EN adds a saturating stall_count output.
module hazard_forward_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W       = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r,
  input  logic                  id_is_branch,
  input  logic                  branch_taken,
  input  logic                  jump_taken,
  input  logic                  terminate,
  output logic                  harzard,
  output logic                  if_flush,
  output logic [1:0]            fwd_a_id,
  output logic [1:0]            fwd_b_id,
  output logic [1:0]            fwd_a_ex,
  output logic [1:0]            fwd_b_ex,
  output logic                  halted
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stall_count
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [REG_ADDR_W-1:0] ex_dst, ex_rs, ex_rt, mem_dst, wb_dst;
  logic                  ex_wb_en, ex_mem_r, ex_use_rs, ex_use_rt;
  logic                  mem_wb_en, mem_mem_r, wb_wb_en;
  logic                  term_pending;
  logic [CNT_W-1:0]      drain_cnt;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, branch_ex, branch_mem_load;
  logic ex_load, term_fire;

  // Register 0 is hardwired to zero, so a write to it never produces a dependency.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst,
                                     input logic                  wb_en);
    return (src != '0) && (src == dst) && wb_en;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic                  use_src,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic [REG_ADDR_W-1:0] m_dst,
                                         input logic                  m_wb_en,
                                         input logic                  m_mem_r,
                                         input logic [REG_ADDR_W-1:0] w_dst,
                                         input logic                  w_wb_en);
    if (use_src && reg_match(src, m_dst, m_wb_en) && !m_mem_r) return 2'b01;
    if (use_src && reg_match(src, w_dst, w_wb_en))             return 2'b10;
    return 2'b00;
  endfunction

  assign rs_ex  = id_use_rs && reg_match(id_rs, ex_dst, ex_wb_en);
  assign rt_ex  = id_use_rt && reg_match(id_rt, ex_dst, ex_wb_en);
  assign rs_mem = id_use_rs && reg_match(id_rs, mem_dst, mem_wb_en);
  assign rt_mem = id_use_rt && reg_match(id_rt, mem_dst, mem_wb_en);

  // Branches compare in ID, so they must also wait for any EX result and for a load still in MEM.
  assign load_use        = (rs_ex || rt_ex) && ex_mem_r;
  assign branch_ex       = id_is_branch && (rs_ex || rt_ex);
  assign branch_mem_load = id_is_branch && (rs_mem || rt_mem) && mem_mem_r;
  assign harzard         = id_valid && !halted && (load_use || branch_ex || branch_mem_load);

  assign if_flush = (branch_taken || jump_taken) && id_valid && !harzard;

  assign fwd_a_id = fwd_sel(1'b1, id_rs, mem_dst, mem_wb_en, mem_mem_r, wb_dst, wb_wb_en);
  assign fwd_b_id = fwd_sel(1'b1, id_rt, mem_dst, mem_wb_en, mem_mem_r, wb_dst, wb_wb_en);
  assign fwd_a_ex = fwd_sel(ex_use_rs, ex_rs, mem_dst, mem_wb_en, mem_mem_r, wb_dst, wb_wb_en);
  assign fwd_b_ex = fwd_sel(ex_use_rt, ex_rt, mem_dst, mem_wb_en, mem_mem_r, wb_dst, wb_wb_en);

  assign ex_load   = id_valid && !harzard && !halted && !term_pending;
  assign term_fire = terminate && ex_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      {ex_dst, ex_rs, ex_rt, ex_wb_en, ex_mem_r, ex_use_rs, ex_use_rt} <= '0;
      {mem_dst, mem_wb_en, mem_mem_r} <= '0;
      {wb_dst, wb_wb_en} <= '0;
    end else begin
      mem_dst   <= ex_dst;
      mem_wb_en <= ex_wb_en;
      mem_mem_r <= ex_mem_r;
      wb_dst    <= mem_dst;
      wb_wb_en  <= mem_wb_en;
      if (ex_load) begin
        ex_dst    <= id_dst;
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_wb_en  <= id_wb_en;
        ex_mem_r  <= id_mem_r;
        ex_use_rs <= id_use_rs;
        ex_use_rt <= id_use_rt;
      end else begin
        {ex_dst, ex_rs, ex_rt, ex_wb_en, ex_mem_r, ex_use_rs, ex_use_rt} <= '0;
      end
    end
  end

  // Drain counter reaches zero on the same edge that raises halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_pending <= 1'b0;
      drain_cnt    <= '0;
      halted       <= 1'b0;
    end else if (term_pending) begin
      drain_cnt <= drain_cnt - 1'b1;
      if (drain_cnt <= CNT_W'(1)) begin
        term_pending <= 1'b0;
        halted       <= 1'b1;
      end
    end else if (term_fire) begin
      term_pending <= 1'b1;
      drain_cnt    <= CNT_W'(DRAIN_CYCLES);
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (harzard && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized + directed scoreboard bench for hazard_forward_unit against an instruction-level pipeline model.
module tb_hazard_forward_unit;
  localparam int W     = 5;
  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wb_en = 1'b0, id_mem_r = 1'b0;
  logic id_is_branch = 1'b0, branch_taken = 1'b0, jump_taken = 1'b0, terminate = 1'b0;
  logic [W-1:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic harzard, if_flush, halted;
  logic [1:0] fwd_a_id, fwd_b_id, fwd_a_ex, fwd_b_ex;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_wb_en(id_wb_en),
    .id_mem_r(id_mem_r), .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .jump_taken(jump_taken), .terminate(terminate), .harzard(harzard), .if_flush(if_flush),
    .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id), .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
    .halted(halted)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid; int rs; int rt; bit urs; bit urt; int dst;
    bit wb; bit ld; bit br; bit bt; bit jt; bit term;
  } instr_t;

  typedef struct {
    bit haz; bit flush; bit halted; int fa_id; int fb_id; int fa_ex; int fb_ex; int stalls; int cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB as whole instruction records.
  instr_t pipe[3];
  int     cyc_m, term_cyc, stalls_m;
  bit     term_seen;

  function automatic instr_t nop();
    instr_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic instr_t alu(int d, int s, int t);
    instr_t i = nop();
    i.valid = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.dst = d; i.wb = 1;
    return i;
  endfunction

  function automatic instr_t lw(int d, int base);
    instr_t i = nop();
    i.valid = 1; i.rs = base; i.urs = 1; i.dst = d; i.wb = 1; i.ld = 1;
    return i;
  endfunction

  function automatic instr_t br(int s, int t, bit taken);
    instr_t i = nop();
    i.valid = 1; i.rs = s; i.rt = t; i.urs = 1; i.urt = 1; i.br = 1; i.bt = taken;
    return i;
  endfunction

  function automatic instr_t jr(int s);
    instr_t i = nop();
    i.valid = 1; i.rs = s; i.urs = 1; i.jt = 1;
    return i;
  endfunction

  function automatic instr_t term_i();
    instr_t i = nop();
    i.valid = 1; i.term = 1;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i = nop();
    i.valid = ($urandom_range(0, 9) != 0);
    i.rs = $urandom_range(0, 7); i.rt = $urandom_range(0, 7); i.dst = $urandom_range(0, 7);
    i.urs = $urandom_range(0, 1); i.urt = $urandom_range(0, 1);
    i.ld = ($urandom_range(0, 3) == 0);
    i.wb = i.ld | bit'($urandom_range(0, 1));
    i.br = ($urandom_range(0, 3) == 0);
    i.bt = i.br & bit'($urandom_range(0, 1));
    i.jt = !i.br && ($urandom_range(0, 9) == 0);
    return i;
  endfunction

  function automatic bit writes(instr_t s, int r);
    return (r != 0) && s.wb && (s.dst == r);
  endfunction

  function automatic bit m_halted();
    return term_seen && (cyc_m >= term_cyc + DRAIN + 1);
  endfunction

  // A value still in EX cannot reach ID or EX in time if it is a load or feeds a branch compare.
  function automatic bit depends_unready(instr_t in, int r);
    if (writes(pipe[0], r) && (pipe[0].ld || in.br)) return 1;
    if (in.br && writes(pipe[1], r) && pipe[1].ld)  return 1;
    return 0;
  endfunction

  function automatic int source_of(int r);
    if (writes(pipe[1], r) && !pipe[1].ld) return 1;
    if (writes(pipe[2], r))                return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = nop();
    cyc_m = 0; term_cyc = 0; stalls_m = 0; term_seen = 0;
  endfunction

  task automatic applyStimulus(input instr_t in, output bit stalled);
    exp_t e;
    bit   pend_or_halt;
    @(posedge clk); #1;
    rst = 0;
    id_valid = in.valid; id_rs = in.rs[W-1:0]; id_rt = in.rt[W-1:0]; id_dst = in.dst[W-1:0];
    id_use_rs = in.urs; id_use_rt = in.urt; id_wb_en = in.wb; id_mem_r = in.ld;
    id_is_branch = in.br; branch_taken = in.bt; jump_taken = in.jt; terminate = in.term;
    e.halted = m_halted();
    e.haz    = in.valid && !e.halted &&
               ((in.urs && depends_unready(in, in.rs)) || (in.urt && depends_unready(in, in.rt)));
    e.flush  = (in.bt || in.jt) && in.valid && !e.haz;
    e.fa_id  = source_of(in.rs);
    e.fb_id  = source_of(in.rt);
    e.fa_ex  = pipe[0].urs ? source_of(pipe[0].rs) : 0;
    e.fb_ex  = pipe[0].urt ? source_of(pipe[0].rt) : 0;
    e.stalls = stalls_m;
    e.cyc    = cyc_m;
    exp_q.push_back(e);
    if (e.haz) stalls_m++;
    pend_or_halt = term_seen;
    if (in.term && in.valid && !e.haz && !term_seen) begin
      term_seen = 1;
      term_cyc  = cyc_m;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (in.valid && !e.haz && !pend_or_halt) ? in : nop();
    cyc_m++;
    stalled = e.haz;
  endtask

  // Hold the instruction in ID for as long as the model says it is stalled.
  task automatic issue(input instr_t in);
    bit st;
    int tries = 0;
    do begin
      applyStimulus(in, st);
      tries++;
    end while (st && tries < 6);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(nop());
  endtask

  task automatic doReset(input int n);
    @(posedge clk); #1;
    rst = 1;
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wb_en = 0; id_mem_r = 0;
    id_is_branch = 0; branch_taken = 0; jump_taken = 0; terminate = 0;
    repeat (n - 1) @(posedge clk);
    model_reset();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req, input int cyc);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at model cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("harzard",  64'(harzard),  64'(e.haz),    e.cyc);
        checkOutput("if_flush", 64'(if_flush), 64'(e.flush),  e.cyc);
        checkOutput("halted",   64'(halted),   64'(e.halted), e.cyc);
        checkOutput("fwd_a_id", 64'(fwd_a_id), 64'(e.fa_id),  e.cyc);
        checkOutput("fwd_b_id", 64'(fwd_b_id), 64'(e.fb_id),  e.cyc);
        checkOutput("fwd_a_ex", 64'(fwd_a_ex), 64'(e.fa_ex),  e.cyc);
        checkOutput("fwd_b_ex", 64'(fwd_b_ex), 64'(e.fb_ex),  e.cyc);
`ifdef HAZARD_STATS_EN
        checkOutput("stall_count", 64'(stall_count), 64'(e.stalls), e.cyc);
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    bit st;
    model_reset();
    doReset(2);
    issue(nop());
    $display("[TB] directed: load-use, branch hazards, forwarding priority, flush");
    issue(lw(2, 1));    issue(alu(3, 2, 4));  idle(3);
    issue(alu(5, 1, 1)); issue(br(5, 0, 0));  idle(3);
    issue(lw(6, 1));    issue(br(6, 7, 0));   idle(3);
    issue(alu(8, 1, 2)); issue(alu(8, 3, 4)); issue(alu(9, 8, 8)); idle(3);
    issue(alu(0, 1, 1)); issue(lw(0, 1)); issue(alu(10, 0, 0)); issue(br(0, 0, 1)); idle(3);
    issue(br(1, 2, 1)); idle(2);
    issue(lw(11, 1));   issue(jr(11));        idle(3);

    $display("[TB] random phase");
    for (int n = 0; n < 400; n++) issue(rand_instr());
    idle(3);

    $display("[TB] terminate and drain");
    doReset(1);
    issue(nop());
    issue(alu(1, 2, 3));
    issue(term_i());
    issue(term_i());
    issue(alu(4, 1, 1));
    idle(3);
    for (int n = 0; n < 20; n++) issue(rand_instr());
    doReset(1);
    idle(2);

    $display("[TB] reset during drain and during stall");
    issue(term_i());
    issue(alu(2, 3, 3));
    doReset(1);
    issue(nop());
    for (int n = 0; n < 6; n++) issue(alu(n + 1, n, n));
    issue(lw(2, 1));
    applyStimulus(alu(3, 2, 4), st);
    doReset(2);
    issue(nop());
    issue(alu(3, 2, 4));
    idle(3);
    for (int n = 0; n < 100; n++) issue(rand_instr());
    idle(2);

    @(negedge clk); #1;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0, cyc_m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Produces the `harzard` stall input that the decode control block consumes.
- Produces the forwarding mux selects for the ID-stage branch comparator and the EX-stage ALU operands, plus the IF flush and end-of-program halt.
- Keeps a shadow copy of the destination/write/load info of the instructions in EX, MEM and WB. Decides stalls and forwarding from that copy together with the decoded ID-stage instruction.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- DRAIN_CYCLES, 3, cycles after terminate issue before `halted` asserts (EX, MEM, WB drain).
- STAT_W, 32, width of the stall statistic counter (optional feature only).

Ports:
- clk  input  1  pipeline clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_ADDR_W  ID source register rs.
- id_rt  input  REG_ADDR_W  ID source register rt.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_dst  input  REG_ADDR_W  ID destination register.
- id_wb_en  input  1  ID instruction writes back (from control).
- id_mem_r  input  1  ID instruction is a load.
- id_is_branch  input  1  ID instruction is BEQ/BNE (compare in ID).
- branch_taken  input  1  from control.
- jump_taken  input  1  from control.
- terminate  input  1  from control.
- harzard  output  1  stall: hold PC/IF-ID, insert bubble into EX.
- if_flush  output  1  squash instruction in IF.
- fwd_a_id  output  2  branch rs operand select.
- fwd_b_id  output  2  branch rt operand select.
- fwd_a_ex  output  2  ALU A select.
- fwd_b_ex  output  2  ALU B select.
- halted  output  1  pipeline drained after terminate; sticky.

Behaviour:
- Select encoding, all four select outputs: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- Shadow stage registers ex_*, mem_*, wb_*. Each holds dst, wb_en, mem_r; ex_* also holds rs, rt, use_rs, use_rt.
- Reset clears every shadow register, the terminate/drain state and `halted`. All outputs read 0 in the cycle after reset is sampled.
- Shadow register update per clock:
  - mem_* <= ex_* and wb_* <= mem_*, always.
  - ex_* <= ID fields when id_valid & !harzard & !halted.
  - Otherwise ex_* <= bubble (all zero).
- "Match(x, s)": x != 0, x == s.dst, s.wb_en = 1. Register 0 never matches.
- harzard is combinational and asserts when any of the following holds:
  - Load-use: an ID-used source matches ex with ex.mem_r = 1.
  - Branch vs EX: id_is_branch and an ID-used source matches ex (any writer).
  - Branch vs load in MEM: id_is_branch and an ID-used source matches mem with mem.mem_r = 1.
- harzard is forced 0 while id_valid = 0 or halted = 1.
- Resulting stall lengths:
  - Load then ALU user: 1 stall.
  - ALU op then branch: 1 stall.
  - Load then branch: 2 stalls.
- fwd_*_id:
  - 01 if the source matches mem and mem.mem_r = 0.
  - Else 10 if the source matches wb.
  - Else 00.
- fwd_*_ex:
  - Uses the ex-stage rs/rt with use bits.
  - 01 if it matches mem and mem.mem_r = 0.
  - Else 10 if it matches wb.
  - Else 00.
  - MEM has priority over WB when both match.
- if_flush = (branch_taken | jump_taken) & id_valid & !harzard. When a stall and a taken branch coincide, the flush waits until the stall clears.
- Terminate:
  - terminate & id_valid & !harzard sets term_pending and loads drain counter = DRAIN_CYCLES.
  - Counter decrements each cycle; at 0, halted <= 1.
  - While term_pending or halted, the ex_* load is suppressed (bubbles only).
  - A second terminate while pending is ignored.
  - halted is cleared only by rst.
- Reset asserted mid-stall or mid-drain aborts immediately, with no residual stall.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds output `stall_count` [STAT_W-1:0]:
  - Increments each cycle harzard = 1.
  - Saturates at all-ones.
  - Cleared by rst.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- lw $2 then add $3,$2,$4 → harzard = 1 for exactly 1 cycle. Next cycle fwd_a_ex = 10 (from WB).
- add $5,$1,$1 then beq $5,$0 → harzard 1 cycle. Next cycle fwd_a_id = 01 and fwd_b_id = 00.
- lw $6 then bne $6,$7 → harzard 2 consecutive cycles. Then fwd_a_id = 10.
- add $8; sub $8; or $9,$8,$8 → fwd_a_ex = fwd_b_ex = 01 (MEM wins over WB). Writes to $0 produce no forward and no stall.
- beq taken with no hazard → if_flush = 1 that cycle. j taken during a load-use stall → if_flush = 0 while stalled, then 1.
- terminate issued at cycle T → halted = 1 at T+DRAIN_CYCLES+1 (T+4 default). A later id_valid yields only bubbles. rst clears halted. With HAZARD_STATS_EN, stall_count = 4 after scenarios 1–3.
